fetch_controller: RTL and testbench

Instruction-fetch sequencer on the consumer side of the program counter register. It reads the current `PC`/`PC4`, requests the instruction from the instruction cache, and returns `next_PC` and `stall` so the counter advances exactly once per accepted instruction. It handles redirects (branch/jump) and cache latency, and presents a one-entry instruction buffer to decode.

---
 rtl/fetch_controller_pkg.sv | 16 +
 rtl/fetch_controller_if.sv | 34 +++
 rtl/fetch_buffer.sv | 55 +++++
 rtl/fetch_controller.sv | 143 ++++++++++++++
 tb/tb_fetch_controller.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared CPU types for the instruction-fetch path.
// Contents: fetch sequencer state encoding and the opcode that stops fetch.
// No ports; imported by fetch_controller and its bench.
package fetch_controller_pkg;

  // Opcode field (bits 31:26) that parks the fetch sequencer.
  localparam logic [5:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Signal bundle between the fetch sequencer and its neighbours (program
// counter, instruction cache, execute redirect, decode).
// Modports: fc (the fetch controller's view), tb (the environment's view).
interface fetch_controller_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] PC;
  logic [WORD_W-1:0] PC4;
  logic [WORD_W-1:0] next_PC;
  logic              stall;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              redirect;
  logic [WORD_W-1:0] redirect_target;
  logic              decode_ready;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] instr_pc;
  logic              instr_valid;
  logic              halted;

  modport fc (
    input  PC, PC4, ihit, imemload, redirect, redirect_target, decode_ready,
    output next_PC, stall, imemREN, imemaddr, instr_out, instr_pc,
           instr_valid, halted
  );

  modport tb (
    output PC, PC4, ihit, imemload, redirect, redirect_target, decode_ready,
    input  next_PC, stall, imemREN, imemaddr, instr_out, instr_pc,
           instr_valid, halted
  );
endinterface

// File: rtl/fetch_buffer.sv
// One-entry instruction buffer between fetch and decode.
// Ports: clk_i/rst_ni (sync active-low), capture_i/consume_i/flush_i controls,
//        instr_i/pc_i capture data, instr_o/pc_o/valid_o registered outputs.
module fetch_buffer #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              consume_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] pc_q;
  logic              valid_q;
  logic              valid_d;

  // Flush beats capture (wrong-path data must never become visible);
  // capture beats consume because a capture only happens into a free slot.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (capture_i && !flush_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: requests the word at PC, steers next_PC/stall
// so the program counter advances once per accepted instruction or redirect,
// and feeds decode through a one-entry buffer.
// Ports: CLK/nRST (sync active-low); PC/PC4 in, next_PC/stall out; icache
//        imemREN/imemaddr out, ihit/imemload in; redirect/redirect_target in;
//        decode_ready in; instr_out/instr_pc/instr_valid/halted out (registered).
module fetch_controller #(
  parameter int         WORD_W  = 32,
  parameter logic [5:0] HALT_OP = fetch_controller_pkg::HALT_OP
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] PC,
  input  logic [WORD_W-1:0] PC4,
  output logic [WORD_W-1:0] next_PC,
  output logic              stall,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              decode_ready,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  import fetch_controller_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pend_target_q, pend_target_d;
  logic              halted_q;

  logic buf_free;
  logic buf_capture;
  logic buf_flush;
  logic is_halt;

  assign buf_free = !instr_valid || decode_ready;
  assign is_halt  = (imemload[WORD_W-1 -: 6] == HALT_OP);

  // The cache address never moves while a request is outstanding because the
  // program counter is held (stall=1) until the hit that completes it.
  assign imemaddr = PC;

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    next_PC       = PC;
    stall         = 1'b1;
    imemREN       = 1'b0;
    buf_capture   = 1'b0;
    buf_flush     = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        imemREN = buf_free;
        if (redirect) begin
          // Anything in the buffer is on the wrong path.
          buf_flush = 1'b1;
          if (ihit) begin
            next_PC = redirect_target;
            stall   = 1'b0;
          end else begin
            // A miss may be in flight at PC; finish it before moving PC.
            pend_target_d = redirect_target;
            state_d       = DRAIN;
          end
        end else if (ihit && buf_free) begin
          buf_capture = 1'b1;
          next_PC     = PC4;
          stall       = 1'b0;
          if (is_halt) begin
            state_d = HALTED;
          end
        end
      end

      DRAIN: begin
        imemREN = 1'b1;
        if (redirect) begin
          buf_flush     = 1'b1;
          pend_target_d = redirect_target;
        end
        if (ihit) begin
          // Returned data belongs to the abandoned path and is dropped.
          next_PC = redirect ? redirect_target : pend_target_q;
          stall   = 1'b0;
          state_d = FETCH;
        end
      end

      HALTED: begin
        if (redirect) begin
          buf_flush = 1'b1;
          next_PC   = redirect_target;
          stall     = 1'b0;
          state_d   = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= IDLE;
      pend_target_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      halted_q      <= (state_d == HALTED);
    end
  end

  assign halted = halted_q;

  fetch_buffer #(
    .WORD_W (WORD_W)
  ) u_fetch_buffer (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .capture_i (buf_capture),
    .consume_i (decode_ready),
    .flush_i   (buf_flush),
    .instr_i   (imemload),
    .pc_i      (PC),
    .instr_o   (instr_out),
    .pc_o      (instr_pc),
    .valid_o   (instr_valid)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller with a behavioural
// program counter closing the next_PC/stall loop.
// Combinational outputs are checked before each edge, registered ones after.
module tb_fetch_controller;

  logic        CLK;
  logic        nRST;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] next_PC;
  logic        stall;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        decode_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;

  int n_total;
  int n_pass;

  fetch_controller dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .PC              (PC),
    .PC4             (PC4),
    .next_PC         (next_PC),
    .stall           (stall),
    .imemREN         (imemREN),
    .imemaddr        (imemaddr),
    .ihit            (ihit),
    .imemload        (imemload),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .decode_ready    (decode_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program counter register on the producer side.
  always @(posedge CLK) begin
    if (!nRST) PC <= 32'h0;
    else if (!stall) PC <= next_PC;
  end
  assign PC4 = PC + 32'd4;

  typedef struct {
    logic        nrst, ihit, redir, dr, chk_comb;
    logic [31:0] load, tgt;
    logic        ren, stall;
    logic [31:0] npc, addr;
    logic        vld;
    logic [31:0] ipc, iout;
    logic        halt;
    logic [31:0] pc_after;
  } vec_t;

  function automatic vec_t mk(
    input logic nrst, input logic ih, input logic [31:0] load,
    input logic rd, input logic [31:0] tgt, input logic dr, input logic cc,
    input logic ren, input logic st, input logic [31:0] npc, input logic [31:0] addr,
    input logic vld, input logic [31:0] ipc, input logic [31:0] iout,
    input logic hl, input logic [31:0] pca);
    vec_t v;
    v.nrst = nrst; v.ihit = ih; v.load = load; v.redir = rd; v.tgt = tgt;
    v.dr = dr; v.chk_comb = cc; v.ren = ren; v.stall = st; v.npc = npc;
    v.addr = addr; v.vld = vld; v.ipc = ipc; v.iout = iout; v.halt = hl;
    v.pc_after = pca;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  vec_t vecs[$];

  initial begin
    n_total = 0;
    n_pass  = 0;
    nRST = 1'b0; ihit = 1'b0; imemload = '0; redirect = 1'b0;
    redirect_target = '0; decode_ready = 1'b1;

    //           nrst ih load          rd tgt       dr cc  ren st npc       addr      vld ipc       iout          hl pc_after
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   1, 0,  0, 1, 32'h0,   32'h0,    0, 32'h0,   32'h0,        0, 32'h0));   // reset
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  0, 1, 32'h0,   32'h0,    0, 32'h0,   32'h0,        0, 32'h0));   // IDLE
    vecs.push_back(mk(1, 1, 32'h11,       0, 32'h0,   1, 1,  1, 0, 32'h4,   32'h0,    1, 32'h0,   32'h11,       0, 32'h4));   // streaming
    vecs.push_back(mk(1, 1, 32'h22,       0, 32'h0,   1, 1,  1, 0, 32'h8,   32'h4,    1, 32'h4,   32'h22,       0, 32'h8));
    vecs.push_back(mk(1, 1, 32'h33,       0, 32'h0,   1, 1,  1, 0, 32'hC,   32'h8,    1, 32'h8,   32'h33,       0, 32'hC));
    vecs.push_back(mk(1, 1, 32'h44,       0, 32'h0,   1, 1,  1, 0, 32'h10,  32'hC,    1, 32'hC,   32'h44,       0, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  1, 1, 32'h10,  32'h10,   0, 32'hC,   32'h44,       0, 32'h10));  // 3-cycle miss
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  1, 1, 32'h10,  32'h10,   0, 32'hC,   32'h44,       0, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  1, 1, 32'h10,  32'h10,   0, 32'hC,   32'h44,       0, 32'h10));
    vecs.push_back(mk(1, 1, 32'h55,       0, 32'h0,   1, 1,  1, 0, 32'h14,  32'h10,   1, 32'h10,  32'h55,       0, 32'h14));
    vecs.push_back(mk(1, 1, 32'h66,       1, 32'h80,  1, 1,  1, 0, 32'h80,  32'h14,   0, 32'h10,  32'h55,       0, 32'h80));  // redirect + hit
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  1, 1, 32'h80,  32'h80,   0, 32'h10,  32'h55,       0, 32'h80));  // miss
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h200, 1, 1,  1, 1, 32'h80,  32'h80,   0, 32'h10,  32'h55,       0, 32'h80));  // redirect -> DRAIN
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  1, 1, 32'h80,  32'h80,   0, 32'h10,  32'h55,       0, 32'h80));
    vecs.push_back(mk(1, 1, 32'h77,       0, 32'h0,   1, 1,  1, 0, 32'h200, 32'h80,   0, 32'h10,  32'h55,       0, 32'h200)); // drain hit
    vecs.push_back(mk(1, 1, 32'h88,       0, 32'h0,   1, 1,  1, 0, 32'h204, 32'h200,  1, 32'h200, 32'h88,       0, 32'h204));
    vecs.push_back(mk(1, 1, 32'h99,       0, 32'h0,   0, 1,  0, 1, 32'h204, 32'h204,  1, 32'h200, 32'h88,       0, 32'h204)); // backpressure
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 1,  0, 1, 32'h204, 32'h204,  1, 32'h200, 32'h88,       0, 32'h204));
    vecs.push_back(mk(1, 1, 32'hFC000000, 0, 32'h0,   1, 1,  1, 0, 32'h208, 32'h204,  1, 32'h204, 32'hFC000000, 1, 32'h208)); // halt op
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 1,  0, 1, 32'h208, 32'h208,  1, 32'h204, 32'hFC000000, 1, 32'h208));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h100, 0, 1,  0, 0, 32'h100, 32'h208,  0, 32'h204, 32'hFC000000, 0, 32'h100)); // un-halt
    vecs.push_back(mk(1, 1, 32'hAA,       0, 32'h0,   1, 1,  1, 0, 32'h104, 32'h100,  1, 32'h100, 32'hAA,       0, 32'h104));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h300, 1, 1,  1, 1, 32'h104, 32'h104,  0, 32'h100, 32'hAA,       0, 32'h104)); // newest wins
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h400, 1, 1,  1, 1, 32'h104, 32'h104,  0, 32'h100, 32'hAA,       0, 32'h104));
    vecs.push_back(mk(1, 1, 32'hCC,       0, 32'h0,   1, 1,  1, 0, 32'h400, 32'h104,  0, 32'h100, 32'hAA,       0, 32'h400));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h500, 1, 1,  1, 1, 32'h400, 32'h400,  0, 32'h100, 32'hAA,       0, 32'h400)); // drain redirect+hit
    vecs.push_back(mk(1, 1, 32'hDD,       1, 32'h600, 1, 1,  1, 0, 32'h600, 32'h400,  0, 32'h100, 32'hAA,       0, 32'h600));
    vecs.push_back(mk(1, 1, 32'hBB,       0, 32'h0,   1, 1,  1, 0, 32'h604, 32'h600,  1, 32'h600, 32'hBB,       0, 32'h604));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h700, 0, 1,  0, 1, 32'h604, 32'h604,  0, 32'h600, 32'hBB,       0, 32'h604)); // flush w/o ready
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 1,  1, 1, 32'h604, 32'h604,  0, 32'h600, 32'hBB,       0, 32'h604));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 1,  1, 1, 32'h604, 32'h604,  0, 32'h0,   32'h0,        0, 32'h0));   // reset in DRAIN
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 1,  0, 1, 32'h0,   32'h0,    0, 32'h0,   32'h0,        0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge CLK);
      nRST            = vecs[i].nrst;
      ihit            = vecs[i].ihit;
      imemload        = vecs[i].load;
      redirect        = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      decode_ready    = vecs[i].dr;
      #1;
      if (vecs[i].chk_comb) begin
        chk($sformatf("r%0d_imemREN", i), {31'h0, imemREN}, {31'h0, vecs[i].ren});
        chk($sformatf("r%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].stall});
        chk($sformatf("r%0d_next_PC", i), next_PC, vecs[i].npc);
        chk($sformatf("r%0d_imemaddr", i), imemaddr, vecs[i].addr);
      end
      @(posedge CLK);
      #1;
      chk($sformatf("r%0d_instr_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].vld});
      chk($sformatf("r%0d_instr_pc", i), instr_pc, vecs[i].ipc);
      chk($sformatf("r%0d_instr_out", i), instr_out, vecs[i].iout);
      chk($sformatf("r%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].halt});
      chk($sformatf("r%0d_PC", i), PC, vecs[i].pc_after);
    end

    // Hand sequence: halt fetched at PC 0 with decode stalled, then reset
    // while halted must clear every registered output.
    @(negedge CLK);
    ihit = 1'b1; imemload = 32'hFC000000; redirect = 1'b0; decode_ready = 1'b0;
    @(posedge CLK);
    #1;
    chk("hs_halted_set", {31'h0, halted}, 32'h1);
    chk("hs_valid_set", {31'h0, instr_valid}, 32'h1);
    chk("hs_pc_adv", PC, 32'h4);
    @(negedge CLK);
    ihit = 1'b0;
    #1;
    chk("hs_halted_ren", {31'h0, imemREN}, 32'h0);
    chk("hs_halted_stall", {31'h0, stall}, 32'h1);
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    chk("hs_rst_halted", {31'h0, halted}, 32'h0);
    chk("hs_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("hs_rst_instr", instr_out, 32'h0);
    chk("hs_rst_ren", {31'h0, imemREN}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
